// File: rtl/clock_tick_timer_if.sv
// Control/status bundle for clock_tick_timer: run control and programming
// from the master side, tick/busy/done/count reported back by the timer.
interface clock_tick_timer_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic [DIV_W-1:0] div_val;
  logic [CNT_W-1:0] limit;
  logic             tick;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;

  modport master (
    output start, stop, div_val, limit,
    input  tick, busy, done, count
  );

  modport slave (
    input  start, stop, div_val, limit,
    output tick, busy, done, count
  );
endinterface

// File: rtl/clock_tick_timer.sv
// Programmable tick divider with a tick-count limit and a one-cycle done pulse.
// Optional macro TIMER_AUTO_RELOAD_EN: restart the run after every done pulse.
module clock_tick_timer #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input logic               clock,
  input logic               reset,
  clock_tick_timer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and registered-output decode. A run launch lands the first
  // cycle at prescaler 0, so a divider of 0 already ticks in that cycle.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    lim_d   = lim_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = S_RUN;
          div_d   = bus.div_val;
          lim_d   = bus.limit;
          pre_d   = DIV_ZERO;
          tick_d  = (bus.div_val == DIV_ZERO) && (bus.limit != CNT_ZERO);
          cnt_d   = tick_d ? CNT_ONE : CNT_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (cnt_q == lim_q) begin
          state_d = S_DONE;
        end else begin
          pre_d  = (pre_q == div_q) ? DIV_ZERO : pre_q + DIV_ONE;
          tick_d = (pre_d == div_q);
          cnt_d  = tick_d ? cnt_q + CNT_ONE : cnt_q;
        end
      end
      S_DONE: begin
`ifdef TIMER_AUTO_RELOAD_EN
        if (bus.stop) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
          pre_d   = DIV_ZERO;
          tick_d  = (div_q == DIV_ZERO) && (lim_q != CNT_ZERO);
          cnt_d   = tick_d ? CNT_ONE : CNT_ZERO;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= DIV_ZERO;
      lim_q   <= CNT_ZERO;
      pre_q   <= DIV_ZERO;
      cnt_q   <= CNT_ZERO;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      lim_q   <= lim_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tick  = tick_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.count = cnt_q;

endmodule

// File: tb/tb_clock_tick_timer.sv
// Randomized and directed bench for clock_tick_timer against a cycle-index
// reference model of one run (ticks, done position, held count).
module tb_clock_tick_timer;
  localparam int DIV_W = 8;
  localparam int CNT_W = 16;
`ifdef TIMER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  clock_tick_timer_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  clock_tick_timer #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;

  // Model: while active, m_c is the 1-based cycle index since the launch edge.
  bit m_active = 1'b0;
  int m_c      = 0;
  int m_d      = 0;
  int m_l      = 0;
  int m_hold   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int run_len();
    int r;
    r = m_l * (m_d + 1);
    return (r > 0) ? r : 1;
  endfunction

  function automatic int exp_busy();
    return (m_active && m_c <= run_len()) ? 1 : 0;
  endfunction

  function automatic int exp_done();
    return (m_active && m_c == run_len() + 1) ? 1 : 0;
  endfunction

  function automatic int exp_tick();
    return (exp_busy() == 1 && m_l > 0 && (m_c % (m_d + 1)) == 0) ? 1 : 0;
  endfunction

  function automatic int exp_count();
    int t;
    if (!m_active) return m_hold;
    if (m_c > run_len()) return m_l;
    t = m_c / (m_d + 1);
    return (t < m_l) ? t : m_l;
  endfunction

  task automatic model_edge(input bit st, input bit sp, input bit rs, input int dv, input int lm);
    if (rs) begin
      m_active = 1'b0;
      m_hold   = 0;
    end else if (m_active) begin
      if (m_c <= run_len()) begin
        if (sp) begin
          m_hold   = exp_count();
          m_active = 1'b0;
        end else begin
          m_c++;
        end
      end else if (AUTO && !sp) begin
        m_c = 1;
      end else begin
        m_hold   = m_l;
        m_active = 1'b0;
      end
    end else if (st && !sp) begin
      m_active = 1'b1;
      m_c      = 1;
      m_d      = dv;
      m_l      = lm;
    end
  endtask

  task automatic step(input bit st, input bit sp, input bit rs, input int dv, input int lm);
    logic [31:0] dv_v;
    logic [31:0] lm_v;
    dv_v        = dv;
    lm_v        = lm;
    bus.start   = st;
    bus.stop    = sp;
    reset       = rs;
    bus.div_val = dv_v[DIV_W-1:0];
    bus.limit   = lm_v[CNT_W-1:0];
    @(posedge clock);
    model_edge(st, sp, rs, dv, lm);
    @(negedge clock);
    chk("tick",  int'(bus.tick),  exp_tick());
    chk("busy",  int'(bus.busy),  exp_busy());
    chk("done",  int'(bus.done),  exp_done());
    chk("count", int'(bus.count), exp_count());
  endtask

  initial begin
    int cyc;
    int done_cyc;
    int tick_sum;
    int ndone;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.div_val = 8'd0;
    bus.limit   = 16'd0;

    // reset state, then reset held for two cycles in the middle of a run
    step(1'b0, 1'b0, 1'b1, 0, 0);
    step(1'b0, 1'b0, 1'b1, 0, 0);
    step(1'b1, 1'b0, 1'b0, 3, 4);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 0, 0);
    step(1'b0, 1'b0, 1'b1, 0, 0);
    chk("rst_busy",  int'(bus.busy),  0);
    chk("rst_count", int'(bus.count), 0);
    step(1'b0, 1'b0, 1'b0, 0, 0);

    // div 3 / limit 4: ticks at cycles 4,8,12,16 and done at 17
    step(1'b1, 1'b0, 1'b0, 3, 4);
    cyc = 1; done_cyc = 0; tick_sum = 0;
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b0, 1'b0, 0, 0);
      cyc++;
      if (bus.tick === 1'b1) tick_sum += cyc;
      if (bus.done === 1'b1 && done_cyc == 0) done_cyc = cyc;
    end
    chk("t2_done_cycle", done_cyc, 17);
    chk("t2_tick_cycles", tick_sum, 4 + 8 + 12 + 16);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 0);

    // div 0 / limit 0: no tick, done in cycle 2
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 0);
    chk("t3_done", int'(bus.done), 1);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 0);

    // div 2 / limit 10, stop during cycle 7
    step(1'b1, 1'b0, 1'b0, 2, 10);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    chk("t4_busy", int'(bus.busy), 0);
    chk("t4_count", int'(bus.count), 2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 0, 0);

    // start+stop together in idle, then restart attempt during a run
    step(1'b1, 1'b1, 1'b0, 1, 3);
    step(1'b1, 1'b0, 1'b0, 1, 3);
    step(1'b1, 1'b0, 1'b0, 5, 9);
    step(1'b1, 1'b0, 1'b0, 5, 9);
    ndone = 0;
    for (int i = 0; i < 19; i++) begin
      step(1'b0, 1'b0, 1'b0, 0, 0);
      if (bus.done === 1'b1) ndone++;
    end
    chk("t6_dones", ndone, AUTO ? 3 : 1);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit st;
      bit sp;
      bit rs;
      int dv;
      int lm;
      st = ($urandom_range(0, 3) == 0);
      sp = ($urandom_range(0, 29) == 0);
      rs = ($urandom_range(0, 299) == 0);
      dv = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 4);
      lm = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6);
      if (dv > 20 && lm > 4) lm = 4;
      step(st, sp, rs, dv, lm);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
